// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan decoder: glyph patterns,
// digit/slot sizing, FSM state encoding and anode classification helpers.
package seg_pkg;

    localparam int DIGIT_W    = 5;
    localparam int NUM_DIGITS = 4;

    // Active-high segment patterns, bit 6 = A ... bit 0 = G
    localparam logic [6:0] GLYPH_0 = 7'b1111110;
    localparam logic [6:0] GLYPH_1 = 7'b0110000;
    localparam logic [6:0] GLYPH_2 = 7'b1101101;
    localparam logic [6:0] GLYPH_3 = 7'b1111001;
    localparam logic [6:0] GLYPH_4 = 7'b0110011;
    localparam logic [6:0] GLYPH_5 = 7'b1011011;
    localparam logic [6:0] GLYPH_6 = 7'b1011111;
    localparam logic [6:0] GLYPH_7 = 7'b1110000;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1110011;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b0011111;
    localparam logic [6:0] GLYPH_C = 7'b1001110;
    localparam logic [6:0] GLYPH_D = 7'b0111101;
    localparam logic [6:0] GLYPH_E = 7'b1001111;
    localparam logic [6:0] GLYPH_F = 7'b1000111;

    typedef enum logic [1:0] {WAIT, SETTLE, HELD} state_t;

    typedef enum logic [1:0] {A_BLANK, A_SEL, A_ILLEGAL} anode_class_t;

    function automatic anode_class_t anode_class(input logic [3:0] a);
        anode_class_t c;
        case (a)
            4'hF:                   c = A_BLANK;
            4'hE, 4'hD, 4'hB, 4'h7: c = A_SEL;
            default:                c = A_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] anode_idx(input logic [3:0] a);
        logic [1:0] i;
        case (a)
            4'hD:    i = 2'd1;
            4'hB:    i = 2'd2;
            4'h7:    i = 2'd3;
            default: i = 2'd0;
        endcase
        return i;
    endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Reverse lookup of an active-high ABCDEFG pattern into a hex value; any
// pattern that is not one of the sixteen glyphs reports 4'hF with err set.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [6:0] glyph,
    output logic [3:0] value,
    output logic       err
);

    always_comb begin
        value = 4'hF;
        err   = 1'b0;
        case (glyph)
            GLYPH_0: value = 4'h0;
            GLYPH_1: value = 4'h1;
            GLYPH_2: value = 4'h2;
            GLYPH_3: value = 4'h3;
            GLYPH_4: value = 4'h4;
            GLYPH_5: value = 4'h5;
            GLYPH_6: value = 4'h6;
            GLYPH_7: value = 4'h7;
            GLYPH_8: value = 4'h8;
            GLYPH_9: value = 4'h9;
            GLYPH_A: value = 4'hA;
            GLYPH_B: value = 4'hB;
            GLYPH_C: value = 4'hC;
            GLYPH_D: value = 4'hD;
            GLYPH_E: value = 4'hE;
            GLYPH_F: value = 4'hF;
            default: err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers 4-digit codes from an active-low multiplexed seven-segment scan:
// settles each anode, decodes its glyph, and publishes complete frames.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 64,
    parameter int STALE_CYCLES  = 200000,
    parameter int CNT_W         = 18
) (
    input  logic        mclk,
    input  logic        rst_N,
    input  logic [3:0]  anode_sel,
    input  logic [7:0]  segments_in,
    output logic [19:0] digits_out,
    output logic        frame_valid,
    output logic [3:0]  digit_err,
    output logic        anode_err,
    output logic        stale
);

    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SC_W-1:0]  SETTLE_LIM = SC_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] STALE_LIM  = CNT_W'(STALE_CYCLES);

    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] slots_t;

    logic [3:0]            a_q, a_d, a_prev_q, a_prev_d;
    logic [7:0]            s_q, s_d, s_prev_q, s_prev_d;
    state_t                state_q, state_d;
    logic [SC_W-1:0]       cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    slots_t                slot_q, slot_d;
    logic [NUM_DIGITS-1:0] slot_err_q, slot_err_d;
    slots_t                digits_q, digits_d;
    logic [NUM_DIGITS-1:0] digit_err_q, digit_err_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  anode_err_q, anode_err_d;
    logic [CNT_W-1:0]      stale_cnt_q, stale_cnt_d;

    anode_class_t a_cls;
    logic [1:0]   idx;
    logic         a_changed, s_changed, frame_done;
    logic         start, capture;
    logic [3:0]   dec_value;
    logic         dec_err;

    assign a_cls      = anode_class(a_q);
    assign idx        = anode_idx(a_q);
    assign a_changed  = (a_q != a_prev_q);
    assign s_changed  = (s_q != s_prev_q);
    assign frame_done = (mask_q == {NUM_DIGITS{1'b1}});

    seg_glyph_decode u_decode (
        .glyph (~s_q[7:1]),
        .value (dec_value),
        .err   (dec_err)
    );

    always_comb begin
        a_d           = anode_sel;
        s_d           = segments_in;
        a_prev_d      = a_q;
        s_prev_d      = s_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        mask_d        = frame_done ? '0 : mask_q;
        slot_d        = slot_q;
        slot_err_d    = slot_err_q;
        digits_d      = digits_q;
        digit_err_d   = digit_err_q;
        frame_valid_d = frame_done;
        anode_err_d   = 1'b0;
        stale_cnt_d   = stale_cnt_q;
        start         = 1'b0;
        capture       = 1'b0;

        unique case (state_q)
            WAIT: begin
                if (a_cls == A_SEL) start = 1'b1;
            end
            SETTLE: begin
                if (a_changed || s_changed) begin
                    if (a_cls == A_SEL) start = 1'b1;
                    else                state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + SC_W'(1);
                end
            end
            HELD: begin
                // Segment changes are ignored until the anode moves on
                if (a_changed) begin
                    if (a_cls == A_SEL) start = 1'b1;
                    else                state_d = WAIT;
                end
            end
            default: state_d = WAIT;
        endcase

        if (start) begin
            state_d = SETTLE;
            cnt_d   = SC_W'(1);
        end

        if (state_d == SETTLE && cnt_d == SETTLE_LIM) begin
            capture = 1'b1;
            state_d = HELD;
        end

        if (a_cls == A_ILLEGAL) begin
            state_d     = WAIT;
            cnt_d       = '0;
            mask_d      = '0;
            capture     = 1'b0;
            anode_err_d = a_changed;
        end

        if (capture) begin
            slot_d[idx]     = {~s_q[0], dec_value};
            slot_err_d[idx] = dec_err;
            mask_d[idx]     = 1'b1;
        end

        // Slots are read before this cycle's capture lands, so a capture
        // coinciding with completion starts the next frame cleanly.
        if (frame_done) begin
            digits_d    = slot_q;
            digit_err_d = slot_err_q;
            stale_cnt_d = '0;
        end else if (stale_cnt_q != {CNT_W{1'b1}}) begin
            stale_cnt_d = stale_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge mclk) begin
        if (!rst_N) begin
            a_q           <= 4'hF;
            s_q           <= 8'hFF;
            a_prev_q      <= 4'hF;
            s_prev_q      <= 8'hFF;
            state_q       <= WAIT;
            cnt_q         <= '0;
            mask_q        <= '0;
            slot_q        <= '0;
            slot_err_q    <= '0;
            digits_q      <= '0;
            digit_err_q   <= '0;
            frame_valid_q <= 1'b0;
            anode_err_q   <= 1'b0;
            stale_cnt_q   <= '0;
        end else begin
            a_q           <= a_d;
            s_q           <= s_d;
            a_prev_q      <= a_prev_d;
            s_prev_q      <= s_prev_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            slot_q        <= slot_d;
            slot_err_q    <= slot_err_d;
            digits_q      <= digits_d;
            digit_err_q   <= digit_err_d;
            frame_valid_q <= frame_valid_d;
            anode_err_q   <= anode_err_d;
            stale_cnt_q   <= stale_cnt_d;
        end
    end

    assign digits_out  = digits_q;
    assign digit_err   = digit_err_q;
    assign frame_valid = frame_valid_q;
    assign anode_err   = anode_err_q;
    assign stale       = (stale_cnt_q >= STALE_LIM);

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Decodes a multiplexed, active-low 4-digit seven-segment scan back into digit codes: 4 digits × 5 bits, with bit 4 = DP.
- Sits on the display side of the board. Typical uses:
  - monitor/loopback checker for the display driver;
  - front end for capturing an external scanned display into the design.
- Waits for each anode to settle, reverse-maps its segment pattern, assembles a full frame, and flags malformed scans and stale input.

Parameters:
SETTLE_CYCLES, 64, consecutive stable registered samples required before a digit is captured (min 1)
STALE_CYCLES, 200000, cycles without a completed frame before stale asserts (4 refresh periods at 50 kHz refresh count)
CNT_W, 18, width of the stale counter; must satisfy 2^CNT_W > STALE_CYCLES

Ports:
mclk  input  1  system clock
rst_N  input  1  reset; one clock, reset is synchronous and active-low
anode_sel  input  4  active-low digit select; bit0 = D0 ... bit3 = D3
segments_in  input  8  active-low segments; [7]=CA ... [1]=CG, [0]=DP
digits_out  output  20  last complete frame; D3=[19:15], D2=[14:10], D1=[9:5], D0=[4:0]
frame_valid  output  1  one-cycle pulse when digits_out updates
digit_err  output  4  per-digit: pattern in last frame was not a legal glyph
anode_err  output  1  one-cycle pulse on illegal anode pattern
stale  output  1  level; no frame completed within STALE_CYCLES

Behaviour:
- Reset (rst_N low at posedge mclk):
  - digits_out=0, frame_valid=0, digit_err=0, anode_err=0, stale=0.
  - Input registers: a_q=4'hF, s_q=8'hFF.
  - Capture mask, stable counter and stale counter are cleared; FSM goes to WAIT.
  - Reset mid-frame discards partial captures.
- Input stage: anode_sel and segments_in are registered every cycle into a_q and s_q. All decisions use a_q and s_q.
- Anode classes for a_q:
  - BLANK: 4'hF.
  - SEL: exactly one bit low.
  - ILLEGAL: more than one bit low.
- FSM states:
  - WAIT:
    - a_q SEL -> SETTLE, stable count=1.
    - BLANK -> stay.
    - ILLEGAL -> see error rule.
  - SETTLE:
    - If a_q and s_q are unchanged from the previous cycle, increment count.
    - If they changed, restart: count=1 and stay in SETTLE if a_q is SEL; go to WAIT if BLANK.
    - When count reaches SETTLE_CYCLES, capture into slot idx(a_q) and go to HELD.
  - HELD:
    - Stay while a_q is unchanged; no recapture, and segment changes are ignored.
    - a_q changes to another SEL value -> SETTLE, count=1.
    - a_q changes to BLANK -> WAIT.
- With SETTLE_CYCLES=1, capture occurs on the first registered cycle of a new SEL.
- ILLEGAL rule (from any state):
  - anode_err pulses for one cycle.
  - Capture mask cleared; FSM goes to WAIT.
  - digits_out is unchanged.
- Capture:
  - slot[idx] = {~s_q[0], decode(~s_q[7:1])}; the per-slot error bit is set if the pattern is unknown.
  - The capture mask bit is set.
  - A recapture of an already-masked slot overwrites it.
- Decode table (ABCDEFG, active-high):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1110011, A=1110111, B=0011111, C=1001110, D=0111101, E=1001111, F=1000111
  - Any other pattern, including all-off: value 4'hF with the error bit set.
- Frame completion:
  - On the cycle after the capture that makes the mask 4'hF: digits_out and digit_err load from the slots, frame_valid=1 for one cycle, mask clears, stale counter clears.
  - Capture order is irrelevant.
- Stale:
  - Counter increments each cycle and saturates.
  - stale=1 while count >= STALE_CYCLES.
  - stale clears on the frame_valid cycle.
- Total latency: 1 (input reg) + SETTLE_CYCLES + 1 cycle, measured from the last digit's anode edge to frame_valid.

Decomposition:
- Shared package seg_pkg:
  - Glyph constants GLYPH_0..GLYPH_F (ABCDEFG).
  - Digit field width DIGIT_W=5 and slot count NUM_DIGITS=4.
  - FSM state enum {WAIT, SETTLE, HELD}.
- Sub-module seg_glyph_decode: combinational ABCDEFG -> {value[3:0], err}; it is the inverse LUT of the display driver's encoder.

Test Plan:
(All with SETTLE_CYCLES=4, STALE_CYCLES=100.)
- Clean scan, anodes E,D,B,7 each held 10 cycles, segments for digits 1,2,3,4, no DP -> one frame_valid, digits_out=20'h20C41, digit_err=0.
- Anode held only 3 cycles on D2 within an otherwise clean scan -> D2 not captured, no frame_valid until a later ≥4-cycle dwell on D2.
- Segments change on cycle 2 of a D0 dwell of 8 -> capture uses the new pattern, settling after the change (cycle 6).
- a_q=4'b1100 mid-scan -> anode_err pulses once, mask cleared, the next frame needs all 4 digits, digits_out unchanged meanwhile.
- D1 pattern 8'hFF (blank) with D3..D0 = 9, A, blank, 8.DP -> frame_valid, digit_err=4'b0010, slots D3=0x09, D2=0x0A, D0=0x18.
- No anode activity for 100 cycles after reset -> stale=1 at cycle 100, clears on the next frame_valid; rst_N low mid-frame -> all outputs 0, partial frame dropped.
